// File: rtl/frequency_window_controller_if.sv
// ---------------------------------------------------------------------------
// frequency_window_controller_if
// Groups every non-clock signal of the frequency window controller.
//   master : the controller (drives analyzer control and the result bus)
//   slave  : the environment (start/continuous requests, analyzer
//            accumulators, result consumer)
// Signals:
//   start, continuous             : measurement request / auto re-arm
//   analyzer_enable/_clear        : analyzer control (clear is active-low)
//   f0_value, f1_value, unknown   : analyzer tick accumulators
//   result_valid/_ready           : result handshake
//   result_symbol, result_f0/_f1/_unknown : captured decision and counts
//   busy, overrun                 : status (overrun is sticky)
// ---------------------------------------------------------------------------
interface frequency_window_controller_if;
  logic        start;
  logic        continuous;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic [31:0] unknown;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_symbol;
  logic [31:0] result_f0;
  logic [31:0] result_f1;
  logic [31:0] result_unknown;
  logic        busy;
  logic        overrun;

  modport master (
    input  start, continuous, f0_value, f1_value, unknown, result_ready,
    output analyzer_enable, analyzer_clear, result_valid, result_symbol,
           result_f0, result_f1, result_unknown, busy, overrun
  );

  modport slave (
    output start, continuous, f0_value, f1_value, unknown, result_ready,
    input  analyzer_enable, analyzer_clear, result_valid, result_symbol,
           result_f0, result_f1, result_unknown, busy, overrun
  );
endinterface

// File: rtl/frequency_window_controller.sv
// ---------------------------------------------------------------------------
// frequency_window_controller
// Sequences one measurement of an external two-tone analyzer: clear it,
// enable it for a fixed window, let it drain, capture its accumulators and
// decide which symbol (f0 / f1 / ambiguous / none) dominated the window.
// Ports:
//   clock : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : frequency_window_controller_if.master (see interface header)
// ---------------------------------------------------------------------------
module frequency_window_controller #(
  parameter int unsigned WINDOW_TICKS      = 500000,
  parameter int unsigned CLEAR_TICKS       = 2,
  parameter int unsigned DRAIN_TICKS       = 2,
  parameter int unsigned DOMINANCE_PERCENT = 60
) (
  input  logic                           clock,
  input  logic                           reset,
  frequency_window_controller_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    MEASURE  = 3'd2,
    DRAIN    = 3'd3,
    EVALUATE = 3'd4,
    PRESENT  = 3'd5
  } state_t;

  // Counters are loaded with (ticks - 1) on entry and leave at zero, so a
  // state lasts exactly its tick count and the counter never wraps.
  localparam logic [31:0] CLEAR_LOAD  = 32'(CLEAR_TICKS - 1);
  localparam logic [31:0] WINDOW_LOAD = 32'(WINDOW_TICKS - 1);
  localparam logic [31:0] DRAIN_LOAD  = 32'(DRAIN_TICKS - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        overrun_q;
  logic [1:0]  symbol_q;
  logic [31:0] res_f0_q, res_f1_q, res_unk_q;
  logic        handshake_s;
  logic [1:0]  symbol_d;

  // Symbol decision; all arithmetic widened so nothing truncates.
  function automatic logic [1:0] decide(input logic [31:0] f0,
                                        input logic [31:0] f1,
                                        input logic [31:0] unk);
    logic [33:0] total;
    logic [40:0] f0_scaled, f1_scaled, threshold;
    logic [1:0]  sym;
    total     = {2'b00, f0} + {2'b00, f1} + {2'b00, unk};
    f0_scaled = {9'd0, f0} * 41'd100;
    f1_scaled = {9'd0, f1} * 41'd100;
    threshold = 41'(DOMINANCE_PERCENT) * {7'd0, total};
    if (total == 34'd0) begin
      sym = 2'd0;
    end else if ((f0 == f1) && (f0 != 32'd0)) begin
      sym = 2'd3;
    end else if ((f0 > f1) && (f0_scaled >= threshold)) begin
      sym = 2'd1;
    end else if ((f1 > f0) && (f1_scaled >= threshold)) begin
      sym = 2'd2;
    end else begin
      sym = 2'd0;
    end
    return sym;
  endfunction

  assign handshake_s = (state_q == PRESENT) && bus.result_ready;
  assign symbol_d    = decide(bus.f0_value, bus.f1_value, bus.unknown);

  // Next-state and phase-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          cnt_d   = CLEAR_LOAD;
        end else begin
          cnt_d = 32'd0;
        end
      end
      CLEAR: begin
        if (cnt_q == 32'd0) begin
          state_d = MEASURE;
          cnt_d   = WINDOW_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      MEASURE: begin
        if (cnt_q == 32'd0) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 32'd0) begin
          state_d = EVALUATE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      EVALUATE: begin
        state_d = PRESENT;
        cnt_d   = 32'd0;
      end
      PRESENT: begin
        // continuous is looked at only here, so mid-run changes wait for it.
        if (handshake_s && bus.continuous) begin
          state_d = CLEAR;
          cnt_d   = CLEAR_LOAD;
        end else if (handshake_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State, counter and sticky overrun registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // A start outside IDLE is dropped, including alongside a handshake.
      overrun_q <= overrun_q | (bus.start && (state_q != IDLE));
    end
  end

  // Result capture; data is held through PRESENT and after the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      symbol_q  <= 2'd0;
      res_f0_q  <= 32'd0;
      res_f1_q  <= 32'd0;
      res_unk_q <= 32'd0;
    end else if (state_q == EVALUATE) begin
      symbol_q  <= symbol_d;
      res_f0_q  <= bus.f0_value;
      res_f1_q  <= bus.f1_value;
      res_unk_q <= bus.unknown;
    end else begin
      symbol_q  <= symbol_q;
      res_f0_q  <= res_f0_q;
      res_f1_q  <= res_f1_q;
      res_unk_q <= res_unk_q;
    end
  end

  // Analyzer control decoded straight from the registered state.
  assign bus.analyzer_enable = (state_q == MEASURE);
  assign bus.analyzer_clear  = (state_q == MEASURE) || (state_q == DRAIN) ||
                               (state_q == EVALUATE) || (state_q == PRESENT);
  assign bus.result_valid    = (state_q == PRESENT);
  assign bus.busy            = (state_q != IDLE);
  assign bus.overrun         = overrun_q;
  assign bus.result_symbol   = symbol_q;
  assign bus.result_f0       = res_f0_q;
  assign bus.result_f1       = res_f1_q;
  assign bus.result_unknown  = res_unk_q;

endmodule

// File: tb/tb_frequency_window_controller.sv
// ---------------------------------------------------------------------------
// tb_frequency_window_controller
// Directed bench for frequency_window_controller with a 20-cycle window,
// 2-cycle clear, 2-cycle drain and 60 % dominance. Inputs change 1 time unit
// after the rising edge (or on the falling edge) and outputs are sampled
// 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_frequency_window_controller;

  logic clock;
  logic reset;
  int   check_count;
  int   error_count;

  frequency_window_controller_if bus ();

  frequency_window_controller #(
    .WINDOW_TICKS      (20),
    .CLEAR_TICKS       (2),
    .DRAIN_TICKS       (2),
    .DOMINANCE_PERCENT (60)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Observe from the current cycle until result_valid; lat counts edges.
  task automatic wait_valid(output int lat, output int en_cycles);
    lat       = -1;
    en_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.analyzer_enable === 1'b1) en_cycles++;
      @(posedge clock); #1;
    end
  endtask

  // Pulse start so it is sampled at the next rising edge; returns #1 after it.
  task automatic pulse_start(input logic [31:0] f0, input logic [31:0] f1,
                             input logic [31:0] unk);
    bus.f0_value = f0;
    bus.f1_value = f1;
    bus.unknown  = unk;
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // One result_ready cycle; returns #1 after the handshake edge.
  task automatic handshake();
    bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
  endtask

  // Full non-continuous run checking only the decision.
  task automatic decision_run(input string tag, input logic [31:0] f0,
                              input logic [31:0] f1, input logic [31:0] unk,
                              input logic [1:0] exp_sym);
    int lat, en;
    pulse_start(f0, f1, unk);
    wait_valid(lat, en);
    check_value({tag, "_latency"}, 64'(lat), 64'd25);
    check_value({tag, "_symbol"}, 64'(bus.result_symbol), 64'(exp_sym));
    handshake();
  endtask

  initial begin
    int  lat, en;
    bit  bad;
    check_count      = 0;
    error_count      = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.continuous   = 1'b0;
    bus.result_ready = 1'b0;
    bus.f0_value     = 32'd0;
    bus.f1_value     = 32'd0;
    bus.unknown      = 32'd0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_enable",  64'(bus.analyzer_enable), 64'd0);
    check_value("rst_clear",   64'(bus.analyzer_clear),  64'd0);
    check_value("rst_valid",   64'(bus.result_valid),    64'd0);
    check_value("rst_symbol",  64'(bus.result_symbol),   64'd0);
    check_value("rst_f0",      64'(bus.result_f0),       64'd0);
    check_value("rst_f1",      64'(bus.result_f1),       64'd0);
    check_value("rst_unknown", 64'(bus.result_unknown),  64'd0);
    check_value("rst_busy",    64'(bus.busy),            64'd0);
    check_value("rst_overrun", 64'(bus.overrun),         64'd0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_value("idle_hold_busy", 64'(bus.busy), 64'd0);

    // f0 dominant run: 15/20 = 75 %.
    pulse_start(32'd15, 32'd2, 32'd3);
    check_value("clear_phase_clear", 64'(bus.analyzer_clear), 64'd0);
    check_value("clear_phase_busy",  64'(bus.busy),           64'd1);
    wait_valid(lat, en);
    check_value("f0_latency",  64'(lat),                 64'd25);
    check_value("f0_enable",   64'(en),                  64'd20);
    check_value("f0_symbol",   64'(bus.result_symbol),   64'd1);
    check_value("f0_res_f0",   64'(bus.result_f0),       64'd15);
    check_value("f0_res_f1",   64'(bus.result_f1),       64'd2);
    check_value("f0_res_unk",  64'(bus.result_unknown),  64'd3);
    check_value("f0_overrun",  64'(bus.overrun),         64'd0);
    handshake();
    check_value("hs_valid_drop", 64'(bus.result_valid), 64'd0);
    check_value("hs_data_kept",  64'(bus.result_f0),    64'd15);
    check_value("hs_idle_busy",  64'(bus.busy),         64'd0);

    // Decision table.
    decision_run("tie",      32'd8,  32'd8,  32'd4,  2'd3);
    decision_run("weak_f0",  32'd10, 32'd5,  32'd10, 2'd0);
    decision_run("all_zero", 32'd0,  32'd0,  32'd0,  2'd0);
    decision_run("f1_60pct", 32'd2,  32'd12, 32'd6,  2'd2);

    // Backpressure: 50 cycles of result_ready=0 with two ignored starts.
    pulse_start(32'd15, 32'd2, 32'd3);
    wait_valid(lat, en);
    check_value("bp_latency", 64'(lat), 64'd25);
    bus.f0_value = 32'd99;
    bus.f1_value = 32'd77;
    bus.unknown  = 32'd55;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.start = (i == 10) || (i == 30);
      @(posedge clock); #1;
      if (bus.result_valid !== 1'b1 || bus.result_symbol !== 2'd1 ||
          bus.result_f0 !== 32'd15 || bus.result_f1 !== 32'd2 ||
          bus.result_unknown !== 32'd3 || bus.analyzer_enable !== 1'b0)
        bad = 1'b1;
    end
    bus.start = 1'b0;
    check_value("bp_stable",  64'(bad),         64'd0);
    check_value("bp_overrun", 64'(bus.overrun), 64'd1);
    handshake();
    check_value("bp_hs_valid", 64'(bus.result_valid), 64'd0);

    // Continuous: handshake on first valid cycle, re-arm immediately.
    bus.continuous = 1'b1;
    pulse_start(32'd2, 32'd12, 32'd6);
    wait_valid(lat, en);
    check_value("cont_first_latency", 64'(lat), 64'd25);
    handshake();
    bus.continuous = 1'b0;
    check_value("cont_rearm_busy",  64'(bus.busy),           64'd1);
    check_value("cont_rearm_clear", 64'(bus.analyzer_clear), 64'd0);
    check_value("cont_rearm_valid", 64'(bus.result_valid),   64'd0);
    bus.f0_value = 32'd8;
    bus.f1_value = 32'd8;
    bus.unknown  = 32'd4;
    wait_valid(lat, en);
    check_value("cont_second_latency", 64'(lat),               64'd25);
    check_value("cont_second_enable",  64'(en),                64'd20);
    check_value("cont_second_symbol",  64'(bus.result_symbol), 64'd3);
    handshake();
    check_value("cont_stop_busy", 64'(bus.busy), 64'd0);

    // Reset during the 10th MEASURE cycle.
    pulse_start(32'd15, 32'd2, 32'd3);
    repeat (11) @(posedge clock);
    #1;
    check_value("mid_enable_before", 64'(bus.analyzer_enable), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_value("mid_enable",  64'(bus.analyzer_enable), 64'd0);
    check_value("mid_clear",   64'(bus.analyzer_clear),  64'd0);
    check_value("mid_busy",    64'(bus.busy),            64'd0);
    check_value("mid_overrun", 64'(bus.overrun),         64'd0);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    check_value("mid_no_valid", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
